// File: rtl/usb_rx_pkg.sv
// Shared encodings and defaults for the USB NRZI receive path.
package usb_rx_pkg;

   // Logical line states after J/K mapping: {D+, D-} in full-speed sense
   localparam logic [1:0] LS_SE0 = 2'b00;
   localparam logic [1:0] LS_K   = 2'b01;
   localparam logic [1:0] LS_J   = 2'b10;
   localparam logic [1:0] LS_SE1 = 2'b11;

   localparam int unsigned SYNC_MIN_DEF  = 5;
   localparam int unsigned STUFF_LEN_DEF = 6;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SYNC = 2'd1,
      DATA = 2'd2,
      EOP  = 2'd3
   } rx_state_e;

endpackage

// File: rtl/usb_rx_sampler.sv
// Line synchroniser, J/K mapping and oversampling phase recovery.
module usb_rx_sampler
   import usb_rx_pkg::*;
#(
   parameter int unsigned OVERSAMPLE = 4,
   parameter bit          LOW_SPEED  = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       dp_in,
   input  logic       dm_in,
   output logic [1:0] line_state,
   output logic       sample
);

   localparam int unsigned    PH_W     = $clog2(OVERSAMPLE);
   localparam logic [PH_W-1:0] PH_LAST = PH_W'(OVERSAMPLE - 1);
   localparam logic [PH_W-1:0] PH_MID  = PH_W'(OVERSAMPLE / 2);
   localparam logic           DP_IDLE  = LOW_SPEED ? 1'b0 : 1'b1;

   logic [1:0]      dp_sync;
   logic [1:0]      dm_sync;
   logic [1:0]      ls_c;
   logic [PH_W-1:0] phase;
   logic [PH_W-1:0] phase_c;

   // Two-flop synchronisers, idling at J
   always_ff @(posedge clk) begin
      if (rst) begin
         dp_sync <= {2{DP_IDLE}};
         dm_sync <= {2{~DP_IDLE}};
      end else begin
         dp_sync <= {dp_sync[0], dp_in};
         dm_sync <= {dm_sync[0], dm_in};
      end
   end

   // Map raw pair to logical state; low speed swaps J and K
   always_comb begin
      ls_c = {dp_sync[1], dm_sync[1]};
      if (LOW_SPEED && (ls_c == LS_J || ls_c == LS_K))
         ls_c = ~ls_c;
   end

   // Phase restarts on every line transition, otherwise free-runs
   always_comb begin
      phase_c = '0;
      if (ls_c == line_state && phase != PH_LAST)
         phase_c = phase + PH_W'(1);
   end

   // Register line state, phase and mid-bit sample strobe
   always_ff @(posedge clk) begin
      if (rst) begin
         line_state <= LS_J;
         phase      <= '0;
         sample     <= 1'b0;
      end else begin
         line_state <= ls_c;
         phase      <= phase_c;
         sample     <= (phase_c == PH_MID);
      end
   end

endmodule

// File: rtl/usb_nrzi_rx.sv
// USB receive front end: NRZI decode, SYNC/EOP framing, unstuffing, word assembly.
module usb_nrzi_rx
   import usb_rx_pkg::*;
#(
   parameter int unsigned OVERSAMPLE = 4,
   parameter int unsigned STUFF_LEN  = STUFF_LEN_DEF,
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned SYNC_MIN   = SYNC_MIN_DEF,
   parameter bit          LOW_SPEED  = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              dp_in,
   input  logic              dm_in,
   output logic [DATA_W-1:0] data_out,
   output logic              data_valid,
   output logic              sop,
   output logic              eop,
   output logic              stuff_err,
   output logic              align_err,
   output logic              active
);

   localparam int unsigned ZC_W   = $clog2(SYNC_MIN + 1);
   localparam int unsigned ONES_W = $clog2(STUFF_LEN + 1);
   localparam int unsigned BC_W   = $clog2(DATA_W + 1);

   logic [1:0]        line_state;
   logic              sample;
   logic              jk_c;
   logic              nrzi_bit_c;

   rx_state_e         state, state_n;
   logic [1:0]        prev_level, prev_n;
   logic [ZC_W-1:0]   zero_cnt, zero_n;
   logic [ONES_W-1:0] ones_cnt, ones_n;
   logic [BC_W-1:0]   bit_cnt, bit_n;
   logic [DATA_W-1:0] shreg, shreg_n;
   logic [DATA_W-1:0] data_n;
   logic              dv_n, sop_n, eop_n, serr_n, aerr_n, active_n;

   usb_rx_sampler #(
      .OVERSAMPLE (OVERSAMPLE),
      .LOW_SPEED  (LOW_SPEED)
   ) u_sampler (
      .clk        (clk),
      .rst        (rst),
      .dp_in      (dp_in),
      .dm_in      (dm_in),
      .line_state (line_state),
      .sample     (sample)
   );

   // NRZI: unchanged level decodes as 1
   assign jk_c       = (line_state == LS_J) || (line_state == LS_K);
   assign nrzi_bit_c = (line_state == prev_level);

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         prev_level <= LS_J;
         zero_cnt   <= '0;
         ones_cnt   <= '0;
         bit_cnt    <= '0;
         shreg      <= '0;
         data_out   <= '0;
         data_valid <= 1'b0;
         sop        <= 1'b0;
         eop        <= 1'b0;
         stuff_err  <= 1'b0;
         align_err  <= 1'b0;
         active     <= 1'b0;
      end else begin
         state      <= state_n;
         prev_level <= prev_n;
         zero_cnt   <= zero_n;
         ones_cnt   <= ones_n;
         bit_cnt    <= bit_n;
         shreg      <= shreg_n;
         data_out   <= data_n;
         data_valid <= dv_n;
         sop        <= sop_n;
         eop        <= eop_n;
         stuff_err  <= serr_n;
         align_err  <= aerr_n;
         active     <= active_n;
      end
   end

   // Next-state, unstuffing and framing strobes, one action per sample
   always_comb begin
      state_n  = state;
      prev_n   = prev_level;
      zero_n   = zero_cnt;
      ones_n   = ones_cnt;
      bit_n    = bit_cnt;
      shreg_n  = shreg;
      data_n   = data_out;
      dv_n     = 1'b0;
      sop_n    = 1'b0;
      eop_n    = 1'b0;
      serr_n   = 1'b0;
      aerr_n   = 1'b0;
      active_n = active;

      if (sample) begin
         if (jk_c)
            prev_n = line_state;
         else if (line_state == LS_SE0)
            prev_n = LS_J;

         unique case (state)
            IDLE: begin
               if (line_state == LS_K) begin
                  state_n = SYNC;
                  zero_n  = ZC_W'(1);
               end
            end
            SYNC: begin
               if (!jk_c) begin
                  state_n = IDLE;
               end else if (!nrzi_bit_c) begin
                  if (zero_cnt != '1)
                     zero_n = zero_cnt + ZC_W'(1);
               end else if (zero_cnt >= ZC_W'(SYNC_MIN)) begin
                  state_n  = DATA;
                  sop_n    = 1'b1;
                  active_n = 1'b1;
                  ones_n   = ONES_W'(1);
                  bit_n    = '0;
               end else begin
                  state_n = IDLE;
               end
            end
            DATA: begin
               if (line_state == LS_SE0) begin
                  state_n = EOP;
               end else if (line_state == LS_SE1) begin
                  state_n  = IDLE;
                  active_n = 1'b0;
                  bit_n    = '0;
               end else if (ones_cnt == ONES_W'(STUFF_LEN)) begin
                  // Stuff position: a zero is dropped, a one is a violation
                  if (nrzi_bit_c) begin
                     serr_n   = 1'b1;
                     state_n  = IDLE;
                     active_n = 1'b0;
                     bit_n    = '0;
                  end else begin
                     ones_n = '0;
                  end
               end else begin
                  ones_n  = nrzi_bit_c ? ones_cnt + ONES_W'(1) : '0;
                  shreg_n = {nrzi_bit_c, shreg[DATA_W-1:1]};
                  if (bit_cnt == BC_W'(DATA_W - 1)) begin
                     data_n = shreg_n;
                     dv_n   = 1'b1;
                     bit_n  = '0;
                  end else begin
                     bit_n = bit_cnt + BC_W'(1);
                  end
               end
            end
            EOP: begin
               if (line_state == LS_J) begin
                  eop_n    = 1'b1;
                  aerr_n   = (bit_cnt != '0);
                  active_n = 1'b0;
                  state_n  = IDLE;
                  bit_n    = '0;
               end else if (line_state != LS_SE0) begin
                  state_n  = IDLE;
                  active_n = 1'b0;
                  bit_n    = '0;
               end
            end
         endcase
      end

      // Disable drops any packet in flight silently
      if (!en) begin
         state_n  = IDLE;
         active_n = 1'b0;
         dv_n     = 1'b0;
         sop_n    = 1'b0;
         eop_n    = 1'b0;
         serr_n   = 1'b0;
         aerr_n   = 1'b0;
      end
   end

endmodule

// File: tb/tb_usb_nrzi_rx.sv
// Self-checking bench for usb_nrzi_rx: random packets against a packet-level model.
module tb_usb_nrzi_rx;

   localparam int unsigned OS    = 4;
   localparam int unsigned STUFF = 6;
   localparam int unsigned DW    = 8;
   localparam int unsigned SMIN  = 5;

   localparam logic [1:0] L_SE0 = 2'b00;
   localparam logic [1:0] L_K   = 2'b01;
   localparam logic [1:0] L_J   = 2'b10;

   logic          clk   = 1'b0;
   logic          rst   = 1'b1;
   logic          en    = 1'b0;
   logic          dp_in = 1'b1;
   logic          dm_in = 1'b0;
   logic [DW-1:0] data_out;
   logic          data_valid, sop, eop, stuff_err, align_err, active;

   usb_nrzi_rx #(
      .OVERSAMPLE (OS),
      .STUFF_LEN  (STUFF),
      .DATA_W     (DW),
      .SYNC_MIN   (SMIN),
      .LOW_SPEED  (1'b0)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .dp_in      (dp_in),
      .dm_in      (dm_in),
      .data_out   (data_out),
      .data_valid (data_valid),
      .sop        (sop),
      .eop        (eop),
      .stuff_err  (stuff_err),
      .align_err  (align_err),
      .active     (active)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Output monitor: event counters and received words
   int            cyc = 0;
   int            n_sop = 0, n_eop = 0, n_serr = 0, n_aerr = 0, n_aerr_eop = 0;
   int            act_cyc = 0, sop_cyc = 0, end_cyc = 0;
   logic [DW-1:0] got_q[$];

   always @(negedge clk) begin
      cyc++;
      if (data_valid === 1'b1) got_q.push_back(data_out);
      if (sop === 1'b1) begin n_sop++; sop_cyc = cyc; end
      if (eop === 1'b1) begin n_eop++; end_cyc = cyc; end
      if (stuff_err === 1'b1) begin n_serr++; end_cyc = cyc; end
      if (align_err === 1'b1) begin
         n_aerr++;
         if (eop === 1'b1) n_aerr_eop++;
      end
      if (active === 1'b1) act_cyc++;
   end

   // Stimulus state
   bit            raw_q[$];
   bit            line_q[$];
   logic [DW-1:0] exp_w[$];
   bit            exp_serr;
   int            exp_left;
   logic [1:0]    lvl;
   bit            alt = 1'b0;
   bit            alt_ph = 1'b0;

   task automatic sym(input logic [1:0] ls, input int n);
      dp_in = ls[1];
      dm_in = ls[0];
      repeat (n) @(negedge clk);
   endtask

   task automatic bit_time(output int n);
      if (alt) begin
         n = alt_ph ? 5 : 3;
         alt_ph = !alt_ph;
      end else begin
         n = OS;
      end
   endtask

   task automatic send_bit(input bit b);
      int n;
      if (!b) lvl = (lvl == L_J) ? L_K : L_J;
      bit_time(n);
      sym(lvl, n);
   endtask

   task automatic push_byte(input logic [7:0] b);
      for (int i = 0; i < 8; i++) raw_q.push_back(b[i]);
   endtask

   // Transmitter-side stuffing; the SYNC's closing 1 starts the run
   task automatic stuff_raw();
      int ones = 1;
      line_q.delete();
      foreach (raw_q[i]) begin
         line_q.push_back(raw_q[i]);
         ones = raw_q[i] ? ones + 1 : 0;
         if (ones == STUFF) begin
            line_q.push_back(1'b0);
            ones = 0;
         end
      end
   endtask

   // Reference: unstuff the on-wire bit list and chunk it into LSB-first words
   task automatic model();
      int            ones = 1;
      int            n = 0;
      bit            dead = 1'b0;
      logic [DW-1:0] acc = '0;
      exp_w.delete();
      exp_serr = 1'b0;
      for (int i = 0; i < line_q.size(); i++) begin
         if (!dead) begin
            if (ones == STUFF) begin
               if (line_q[i]) begin
                  exp_serr = 1'b1;
                  dead = 1'b1;
               end else begin
                  ones = 0;
               end
            end else begin
               ones = line_q[i] ? ones + 1 : 0;
               acc[n] = line_q[i];
               n++;
               if (n == DW) begin
                  exp_w.push_back(acc);
                  n = 0;
               end
            end
         end
      end
      exp_left = n;
   endtask

   task automatic send_frame(input int zeros, input bit do_eop);
      lvl = L_J;
      sym(L_J, 16);
      for (int i = 0; i < zeros; i++) send_bit(1'b0);
      send_bit(1'b1);
      foreach (line_q[i]) send_bit(line_q[i]);
      if (do_eop) begin
         sym(L_SE0, 2 * OS);
         sym(L_J, OS + 12);
      end
   endtask

   // Send one framed packet from line_q and compare everything seen against the model
   task automatic run_check(input string tag, input int zeros);
      int s_sop = n_sop, s_eop = n_eop, s_serr = n_serr, s_aerr = n_aerr;
      int s_ae = n_aerr_eop, s_act = act_cyc, s_w = got_q.size();
      bit exp_sop;
      send_frame(zeros, 1'b1);
      model();
      exp_sop = (zeros >= SMIN);
      check($sformatf("%s.sop", tag), 32'(n_sop - s_sop), 32'(exp_sop));
      if (exp_sop) begin
         check($sformatf("%s.nwords", tag), 32'(got_q.size() - s_w), 32'(exp_w.size()));
         for (int i = 0; i < exp_w.size(); i++)
            if (s_w + i < got_q.size())
               check($sformatf("%s.word%0d", tag, i), 32'(got_q[s_w + i]), 32'(exp_w[i]));
         check($sformatf("%s.stuff_err", tag), 32'(n_serr - s_serr), 32'(exp_serr));
         check($sformatf("%s.eop", tag), 32'(n_eop - s_eop), 32'(!exp_serr));
         check($sformatf("%s.align_err", tag), 32'(n_aerr - s_aerr),
               32'(!exp_serr && exp_left != 0));
         check($sformatf("%s.align_with_eop", tag), 32'(n_aerr_eop - s_ae),
               32'(!exp_serr && exp_left != 0));
         check($sformatf("%s.active_cycles", tag), 32'(act_cyc - s_act),
               32'(end_cyc - sop_cyc));
      end else begin
         check($sformatf("%s.nwords", tag), 32'(got_q.size() - s_w), 32'd0);
         check($sformatf("%s.eop", tag), 32'(n_eop - s_eop), 32'd0);
         check($sformatf("%s.errs", tag), 32'((n_serr - s_serr) + (n_aerr - s_aerr)), 32'd0);
         check($sformatf("%s.active", tag), 32'(act_cyc - s_act), 32'd0);
      end
   endtask

   task automatic clean_a5(input string tag);
      alt = 1'b0;
      raw_q.delete();
      push_byte(8'hA5);
      stuff_raw();
      run_check(tag, 7);
   endtask

   // Cut a packet mid-byte with en=0 or rst; expect silent drop then recovery
   task automatic cut_test(input string tag, input bit use_rst);
      int s_eop, s_serr, s_aerr, s_w;
      alt = 1'b0;
      raw_q.delete();
      push_byte(8'hC3);
      stuff_raw();
      while (line_q.size() > 4) void'(line_q.pop_back());
      s_eop = n_eop; s_serr = n_serr; s_aerr = n_aerr; s_w = got_q.size();
      send_frame(7, 1'b0);
      check($sformatf("%s.active_before", tag), 32'(active), 32'd1);
      if (use_rst) rst = 1'b1;
      else         en  = 1'b0;
      sym(lvl, 1);
      check($sformatf("%s.active_after", tag), 32'(active), 32'd0);
      if (use_rst) begin
         check($sformatf("%s.outs_after_rst", tag),
               32'({data_out, data_valid, sop, eop, stuff_err, align_err}), 32'd0);
         rst = 1'b0;
      end
      sym(L_J, 20);
      en = 1'b1;
      sym(L_J, 8);
      check($sformatf("%s.no_eop", tag), 32'(n_eop - s_eop), 32'd0);
      check($sformatf("%s.no_err", tag), 32'((n_serr - s_serr) + (n_aerr - s_aerr)), 32'd0);
      check($sformatf("%s.no_word", tag), 32'(got_q.size() - s_w), 32'd0);
      clean_a5({tag, ".recover"});
   endtask

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      check("reset.data_out", 32'(data_out), 32'd0);
      check("reset.strobes", 32'({data_valid, sop, eop, stuff_err, align_err}), 32'd0);
      check("reset.active", 32'(active), 32'd0);
      rst = 1'b0;
      en  = 1'b1;
      sym(L_J, 4);

      clean_a5("a5");

      raw_q.delete();
      push_byte(8'hFF);
      push_byte(8'h01);
      stuff_raw();
      run_check("ff01", 7);

      raw_q.delete();
      for (int i = 0; i < 7; i++) raw_q.push_back(1'b1);
      line_q = raw_q;
      run_check("seven_ones", 7);

      raw_q.delete();
      push_byte(8'h3C);
      for (int i = 0; i < 3; i++) raw_q.push_back(1'($urandom_range(0, 1)));
      stuff_raw();
      run_check("partial", 7);

      alt = 1'b1;
      alt_ph = 1'b0;
      raw_q.delete();
      push_byte(8'h12);
      push_byte(8'h34);
      push_byte(8'h56);
      push_byte(8'h78);
      stuff_raw();
      run_check("jitter", 7);

      for (int p = 0; p < 12; p++) begin
         int nb;
         alt = 1'($urandom_range(0, 1));
         alt_ph = 1'b0;
         nb = $urandom_range(1, 4);
         raw_q.delete();
         for (int b = 0; b < nb; b++) push_byte(8'($urandom));
         if ($urandom_range(0, 3) == 0) begin
            int extra = $urandom_range(1, DW - 1);
            for (int b = 0; b < extra; b++) raw_q.push_back(1'($urandom_range(0, 1)));
         end
         stuff_raw();
         run_check($sformatf("rand%0d", p), 7);
      end

      cut_test("en_off", 1'b0);
      cut_test("rst_mid", 1'b1);

      alt = 1'b0;
      line_q.delete();
      run_check("short_sync", 3);
      clean_a5("short_sync.recover");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
